// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with registered one-hot grant and owner index.
// Optional hold timeout is compiled in when RR_ARB_TIMEOUT_EN is defined.
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] gnt_idx_q, gnt_idx_d;
    logic [7:0] gnt_q, gnt_d;
    logic       busy_q, busy_d;
    logic [2:0] winner;
    logic       found;
    logic       hold_expired;
    logic       release_grant;

    // First requester at or after ptr, scanning upward with 3-bit wrap.
    always_comb begin
        winner = ptr_q;
        found  = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (!found && req[ptr_q + 3'(i)]) begin
                winner = ptr_q + 3'(i);
                found  = 1'b1;
            end
        end
    end

    assign release_grant = done || !req[gnt_idx_q] || hold_expired;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gnt_idx_q <= '0;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_idx_q <= gnt_idx_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (found) state_d = GRANT;
            GRANT:   if (release_grant) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d     = ptr_q;
        gnt_idx_d = gnt_idx_q;
        gnt_d     = gnt_q;
        busy_d    = busy_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_idx_d = winner;
                    gnt_d     = 8'd1 << winner;
                    busy_d    = 1'b1;
                end
            end
            GRANT: begin
                if (release_grant) begin
                    gnt_d  = '0;
                    busy_d = 1'b0;
                    ptr_d  = gnt_idx_q + 3'd1;
                end
            end
            default: begin
                gnt_d  = '0;
                busy_d = 1'b0;
            end
        endcase
    end

`ifdef RR_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_q, hold_d;
    logic       timeout_q, timeout_d;

    assign hold_expired = (state_q == GRANT) && (hold_q == HOLD_LAST);

    // Timeout is flagged only when no other release cause is present.
    always_comb begin
        hold_d    = '0;
        timeout_d = 1'b0;
        if (state_q == GRANT) begin
            hold_d    = release_grant ? '0 : hold_q + 8'd1;
            timeout_d = hold_expired && !done && req[gnt_idx_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    logic [7:0] unused_max_hold;

    assign unused_max_hold = 8'(MAX_HOLD);
    assign hold_expired    = 1'b0;
    assign timeout         = 1'b0;
`endif

    assign gnt     = gnt_q;
    assign gnt_idx = gnt_idx_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8: stimulus queues expected outputs per cycle,
// a monitor pops and compares them one time unit after each rising edge.
module tb_rr_arbiter8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       busy;
    logic       timeout;

    rr_arbiter8 #(.MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       busy;
        logic       to;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // Drive inputs for one cycle and queue the outputs expected after the next edge.
    task automatic step(input logic [7:0] r, input logic d, input logic [7:0] eg,
                        input logic [2:0] ei, input logic eb, input logic et,
                        input string nm);
        exp_t e;
        req    = r;
        done   = d;
        e.gnt  = eg;
        e.idx  = ei;
        e.busy = eb;
        e.to   = et;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
    endtask

    exp_t  mon_e;
    string mon_nm;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (!$onehot0(gnt)) begin
                n_bad++;
                $display("FAIL onehot: got gnt=%h, want zero or one-hot", gnt);
            end
            if (exp_q.size() > 0) begin
                mon_e  = exp_q.pop_front();
                mon_nm = name_q.pop_front();
                n_cmp++;
                if ({gnt, gnt_idx, busy, timeout} !== mon_e) begin
                    n_bad++;
                    $display("FAIL %s: got gnt=%h idx=%0d busy=%b to=%b, want gnt=%h idx=%0d busy=%b to=%b",
                             mon_nm, gnt, gnt_idx, busy, timeout,
                             mon_e.gnt, mon_e.idx, mon_e.busy, mon_e.to);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        #3;
        step(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, "reset_state");
        rst_n = 1'b1;

        // Single request, then release by done: ptr becomes 3.
        step(8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0, "single_grant");
        step(8'h04, 1'b1, 8'h00, 3'd2, 1'b0, 1'b0, "single_done");
        step(8'h00, 1'b0, 8'h00, 3'd2, 1'b0, 1'b0, "single_idle");

        // Short reset pulse between edges to restart the pointer at 0.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;

        // Full request vector: grants rotate 0..7 then back to 0.
        for (int k = 0; k < 9; k++) begin
            step(8'hFF, 1'b0, 8'(1 << (k % 8)), 3'(k % 8), 1'b1, 1'b0, "rr_grant");
            step(8'hFF, 1'b1, 8'h00, 3'(k % 8), 1'b0, 1'b0, "rr_release");
        end
        step(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, "rr_idle");

        // Grant 5 to move ptr to 6, then wrap to 0 and 1.
        step(8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0, "wrap_g5");
        step(8'h20, 1'b1, 8'h00, 3'd5, 1'b0, 1'b0, "wrap_r5");
        step(8'h03, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0, "wrap_g0");
        step(8'h03, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "wrap_r0");
        step(8'h03, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0, "skip_g1");
        step(8'h03, 1'b1, 8'h00, 3'd1, 1'b0, 1'b0, "skip_r1");
        step(8'h80, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0, "wrap_g7");
        step(8'h80, 1'b1, 8'h00, 3'd7, 1'b0, 1'b0, "wrap_r7");
        step(8'h03, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0, "ptr7to0_g0");
        step(8'h03, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "ptr7to0_r0");

        // Owner 4 abandons, then req drop coincident with done.
        step(8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0, "abandon_g4");
        step(8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0, "abandon_hold");
        step(8'h00, 1'b0, 8'h00, 3'd4, 1'b0, 1'b0, "abandon_rel");
        step(8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0, "coinc_g4");
        step(8'h00, 1'b1, 8'h00, 3'd4, 1'b0, 1'b0, "coinc_rel");
        step(8'h30, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0, "ptr5_g5");
        step(8'h70, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0, "nonowner_ignored");
        step(8'h70, 1'b1, 8'h00, 3'd5, 1'b0, 1'b0, "ptr5_r5");
        step(8'h00, 1'b1, 8'h00, 3'd5, 1'b0, 1'b0, "done_in_idle");

`ifdef RR_ARB_TIMEOUT_EN
        step(8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0, "to_grant");
        for (int k = 0; k < 3; k++)
            step(8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0, "to_hold");
        step(8'h01, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, "to_fire");
        step(8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0, "to_regrant");
        for (int k = 0; k < 3; k++)
            step(8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0, "to_hold2");
        step(8'h01, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "to_done_wins");
`else
        step(8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0, "noto_grant");
        for (int k = 0; k < 110; k++)
            step(8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0, "noto_hold");
        step(8'h01, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "noto_done");
`endif
        step(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, "post_to_idle");

        // Async reset between edges while owner 4 holds the grant.
        step(8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0, "pre_async");
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({gnt, gnt_idx, busy, timeout} !== 13'd0) begin
            n_bad++;
            $display("FAIL async_reset: got gnt=%h idx=%0d busy=%b to=%b, want all zero",
                     gnt, gnt_idx, busy, timeout);
        end
        #1;
        rst_n = 1'b1;
        step(8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0, "post_reset_grant");
        step(8'h10, 1'b1, 8'h00, 3'd4, 1'b0, 1'b0, "post_reset_rel");
        step(8'h00, 1'b0, 8'h00, 3'd4, 1'b0, 1'b0, "final_idle");

        for (int k = 0; k < 4 && exp_q.size() > 0; k++)
            @(negedge clk);
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
